// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce qualification FSM,
// single-cycle load strobe per confirmed press and optional auto-repeat while held.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic BTN_raw,
   output logic BTN_pulse,
   output logic BTN_level,
   output logic BTN_hold
);

   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DCNT_ONE   = DW'(1);
   localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
   localparam logic [HW-1:0] HCNT_ONE   = HW'(1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   state_t        r_state;
   logic [DW-1:0] r_dcnt;
   logic [HW-1:0] r_hcnt;
   logic          r_pulse;
   logic          r_level;
   logic          r_hold;

   state_t        w_stateNext;
   logic [DW-1:0] w_dcntNext;
   logic [HW-1:0] w_hcntNext;
   logic          w_pulseNext;
   logic          w_levelNext;
   logic          w_holdNext;
   logic          w_s;

   assign w_s = r_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= BTN_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_dcnt  <= '0;
         r_hcnt  <= '0;
         r_pulse <= 1'b0;
         r_level <= 1'b0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_dcnt  <= w_dcntNext;
         r_hcnt  <= w_hcntNext;
         r_pulse <= w_pulseNext;
         r_level <= w_levelNext;
         r_hold  <= w_holdNext;
      end
   end

   // hcnt first measures the initial repeat delay, then (once hold is set) is
   // reused as the repeat-period count; it is reloaded at every repeat point.
   always_comb begin
      w_stateNext = r_state;
      w_dcntNext  = r_dcnt;
      w_hcntNext  = r_hcnt;
      w_pulseNext = 1'b0;
      w_levelNext = r_level;
      w_holdNext  = r_hold;

      case (r_state)
         IDLE: begin
            if (w_s) begin
               w_stateNext = PRESS_CHK;
               w_dcntNext  = DCNT_ONE;
            end
         end

         PRESS_CHK: begin
            if (!w_s) begin
               w_stateNext = IDLE;
               w_dcntNext  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
               w_stateNext = PRESSED;
               w_dcntNext  = '0;
               w_hcntNext  = '0;
               w_pulseNext = 1'b1;
               w_levelNext = 1'b1;
            end else begin
               w_dcntNext = r_dcnt + DCNT_ONE;
            end
         end

         PRESSED: begin
            if (!w_s) begin
               w_stateNext = RELEASE_CHK;
               w_dcntNext  = DCNT_ONE;
            end else if (!r_hold) begin
               if (r_hcnt == DELAY_LAST) begin
                  w_holdNext  = 1'b1;
                  w_pulseNext = REPEAT_EN;
                  w_hcntNext  = '0;
               end else begin
                  w_hcntNext = r_hcnt + HCNT_ONE;
               end
            end else begin
               if (r_hcnt == PERIOD_LAST) begin
                  w_pulseNext = REPEAT_EN;
                  w_hcntNext  = '0;
               end else begin
                  w_hcntNext = r_hcnt + HCNT_ONE;
               end
            end
         end

         RELEASE_CHK: begin
            if (w_s) begin
               w_stateNext = PRESSED;
               w_dcntNext  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
               w_stateNext = IDLE;
               w_dcntNext  = '0;
               w_hcntNext  = '0;
               w_levelNext = 1'b0;
               w_holdNext  = 1'b0;
            end else begin
               w_dcntNext = r_dcnt + DCNT_ONE;
            end
         end

         default: begin
            w_stateNext = IDLE;
            w_dcntNext  = '0;
            w_hcntNext  = '0;
            w_levelNext = 1'b0;
            w_holdNext  = 1'b0;
         end
      endcase
   end

   assign BTN_pulse = r_pulse;
   assign BTN_level = r_level;
   assign BTN_hold  = r_hold;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions a raw, asynchronous push-button input into clean control signals for the register-load stage.
- Synchronises the input, debounces it with a qualification FSM, and emits a single-cycle load strobe per confirmed press.
- Optionally emits auto-repeat strobes while the button is held.
- BTN_pulse connects directly to the downstream register's BTN load-enable input.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples required to accept a press or a release (10 ms at 100 MHz); legal range >= 2.
- REPEAT_EN, 0, 1 enables auto-repeat strobes while held; 0 disables them.
- REPEAT_DELAY, 50_000_000, cycles in PRESSED before the first repeat strobe; >= 2.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat strobes; >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- BTN_raw  input  1  raw button level; asynchronous and bouncing.
- BTN_pulse  output  1  one-cycle strobe: confirmed press or repeat.
- BTN_level  output  1  debounced button level.
- BTN_hold  output  1  high once the first repeat point is reached, until release is accepted; independent of REPEAT_EN.

Behaviour:
- Reset is asynchronous and active-high. On assertion, regardless of clock:
  - both synchroniser flops go to 0;
  - state goes to IDLE;
  - all counters go to 0;
  - BTN_pulse, BTN_level and BTN_hold go to 0.
- Synchroniser: two flops. Define s as the second flop. Edge 0 is the edge where flop 1 first samples BTN_raw=1; s=1 after edge 1.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1). Hold counter: width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Neither counter wraps.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if s=1, go to PRESS_CHK with dcnt=1. Otherwise stay.
  - PRESS_CHK: if s=0, return to IDLE with dcnt=0. If s=1 and dcnt==DEBOUNCE_CYCLES-1, go to PRESSED, set BTN_pulse=1 for that one cycle, set BTN_level=1, set hcnt=0. Otherwise increment dcnt.
  - PRESSED: if s=0, go to RELEASE_CHK with dcnt=1. Otherwise increment hcnt.
    - When hcnt reaches REPEAT_DELAY-1 for the first time: set BTN_hold=1; if REPEAT_EN=1, strobe BTN_pulse.
    - After that, each time hcnt has advanced REPEAT_PERIOD further: strobe BTN_pulse if REPEAT_EN=1, and reload the period count.
  - RELEASE_CHK: if s=1, return to PRESSED with dcnt=0. hcnt and the repeat phase are frozen, not reset. If s=0 and dcnt==DEBOUNCE_CYCLES-1, go to IDLE and clear BTN_level, BTN_hold and hcnt. Otherwise increment dcnt. No pulses are issued in this state.
- Press latency: BTN_pulse is high in exactly the cycle following edge DEBOUNCE_CYCLES+1.
- Release latency: BTN_level falls DEBOUNCE_CYCLES+1 edges after the first edge at which BTN_raw is sampled low.
- BTN_pulse is never high for two consecutive cycles, and is never asserted on release.
- Any bounce shorter than DEBOUNCE_CYCLES samples produces no edge on any output.
- BTN_level is 1 exactly in PRESSED and RELEASE_CHK.
- Reset mid-press: after deassertion with BTN_raw still held, the press is re-qualified from IDLE and produces exactly one new BTN_pulse at standard latency.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless noted.
- Clean press: BTN_raw 0->1 held 30 cycles, REPEAT_EN=0 -> exactly one BTN_pulse, high in the cycle after edge 5; BTN_level=1 from the same edge; BTN_hold=1 20 cycles after press acceptance; no further pulses.
- Bounce rejection: BTN_raw toggles 1,0,1,1,0,1,1,1,0 (one value per cycle), then 0 -> BTN_pulse and BTN_level stay 0 throughout.
- Release debounce: from PRESSED, drive BTN_raw low 2 cycles, high 3 cycles, then low permanently -> BTN_level remains 1 through the glitch and falls 5 edges after the final low is first sampled; no pulse on release.
- Auto-repeat: REPEAT_EN=1, hold 60 cycles past acceptance edge E -> BTN_pulse high in cycles E, E+20, E+28, E+36, E+44, E+52 only; BTN_hold rises at E+20.
- Async reset mid-hold: assert reset between clock edges while PRESSED -> all outputs 0 immediately, before the next edge. Release reset with BTN_raw still 1 -> a single BTN_pulse 5 edges later.
- Downstream integration: chain with the 8-bit load register, data=8'hA5, one press -> register holds 8'hA5 from the cycle after the strobe. Change data to 8'h3C with no press -> register holds 8'hA5.
